// File: rtl/equal_compare_pkg.sv
// Shared types for the nibble-serial equality arbiter: FSM states, nibble width
// and the requester-ID type.
package equal_compare_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/equal_comparator_four.sv
// Shared 4-bit equality comparator; the arbiter time-multiplexes it across nibbles.
module equal_comparator_four (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       equal
);

    assign equal = (a == b);

endmodule

// File: rtl/equal_compare_arbiter.sv
// Two-requester round-robin arbiter that compares WIDTH-bit operands one nibble
// per cycle (LSB nibble first) on a single shared comparator, stopping at the first mismatch.
module equal_compare_arbiter
    import equal_compare_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIBBLE_W,
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_equal,
    output logic [IDX_W-1:0] rsp_index,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_NIB = IDX_W'(NIB - 1);

    state_e           state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    req_id_t          id_q, id_d;
    logic [IDX_W-1:0] nib_q, nib_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             equal_q, equal_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    req_id_t              grant;
    logic                 accept;
    logic [NIBBLE_W-1:0]  a_nib, b_nib;
    logic                 nib_equal;

    // Round robin only matters on a tie; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_id_t'(req1_valid);
        end
    end

    // Readies are gated by rst_n so they drop the instant reset asserts.
    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (nib_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    equal_comparator_four u_cmp (
        .a     (a_nib),
        .b     (b_nib),
        .equal (nib_equal)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        nib_d        = nib_q;
        idx_d        = idx_q;
        equal_d      = equal_q;
        a_d          = a_q;
        b_d          = b_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    id_d    = grant;
                    nib_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!nib_equal) begin
                    equal_d = 1'b0;
                    idx_d   = nib_q;
                    state_d = RESP;
                end else if (nib_q == LAST_NIB) begin
                    equal_d = 1'b1;
                    idx_d   = '0;
                    state_d = RESP;
                end else begin
                    nib_d = nib_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            nib_q        <= '0;
            idx_q        <= '0;
            equal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            nib_q        <= nib_d;
            idx_q        <= idx_d;
            equal_q      <= equal_d;
        end
    end

    // Operand latches carry no reset; they are only read while in CMP.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_equal = equal_q;
    assign rsp_index = idx_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_equal_compare_arbiter.sv
// Bench for equal_compare_arbiter (WIDTH=16): directed scenarios plus random traffic,
// scored against a transaction-level reference model.
module tb_equal_compare_arbiter;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_equal, busy;
    logic [IDX_W-1:0] rsp_index;

    always #5 clk = ~clk;

    equal_compare_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_equal  (rsp_equal),
        .rsp_index  (rsp_index),
        .busy       (busy)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               acc;
    } item_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    lg    = 1;
    int    mode  = 0;
    bit    seen  = 0;
    item_t q[$];
    int    grants[$];
    int    last_lat, last_eq, last_idx, last_id;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: first differing nibble from the XOR of the operands.
    function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output int eq, output int idx, output int k);
        logic [WIDTH-1:0] d;
        bit found;
        d = a ^ b;
        found = 0;
        eq = 1; idx = 0; k = NIB;
        for (int i = 0; i < NIB; i++) begin
            if (!found && ((d >> (4 * i)) & 16'hF) != 0) begin
                found = 1; eq = 0; idx = i; k = i + 1;
            end
        end
    endfunction

    function automatic logic [WIDTH-1:0] mutate(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] b;
        int j;
        b = a;
        if ($urandom_range(0, 3) != 0) begin
            j = $urandom_range(0, NIB - 1);
            b = b ^ (WIDTH'($urandom_range(1, 15)) << (4 * j));
        end
        return b;
    endfunction

    // One clock: called at posedge+1 with inputs already driven.
    task automatic step();
        logic r0, r1;
        int   g, eq, idx, k;
        bit   a0, a1;
        #1;
        r0 = req0_ready;
        r1 = req1_ready;
        a0 = 0;
        a1 = 0;
        check("busy", busy, q.size() > 0);
        if (busy) begin
            check("ready_busy", {r1, r0}, 0);
        end else if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? 1 - lg : (req1_valid ? 1 : 0);
            check("grant", {r1, r0}, (g == 1) ? 2 : 1);
        end else begin
            check("ready_idle", {r1, r0}, 0);
        end
        if (rsp_valid) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                ref_cmp(q[0].a, q[0].b, eq, idx, k);
                check("rsp_id", rsp_id, q[0].id);
                check("rsp_equal", rsp_equal, eq);
                check("rsp_index", rsp_index, idx);
                if (!seen) begin
                    check("latency", cyc - q[0].acc, k + 1);
                    last_lat = cyc - q[0].acc;
                    seen = 1;
                end
                if (rsp_ready) begin
                    lg = q[0].id;
                    last_eq = rsp_equal; last_idx = rsp_index; last_id = rsp_id;
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end else if (q.size() > 0) begin
            ref_cmp(q[0].a, q[0].b, eq, idx, k);
            if (cyc - q[0].acc > k + 1) begin
                check("rsp_timeout", cyc - q[0].acc, k + 1);
                void'(q.pop_front());
            end
        end
        if (req0_valid && r0) begin q.push_back('{0, req0_a, req0_b, cyc}); grants.push_back(0); a0 = 1; end
        if (req1_valid && r1) begin q.push_back('{1, req1_a, req1_b, cyc}); grants.push_back(1); a1 = 1; end
        @(posedge clk);
        #1;
        cyc++;
        if (a0) begin
            if (mode == 1) begin req0_a = $urandom; req0_b = mutate(req0_a); end
            else req0_valid = 1'b0;
        end
        if (a1) begin
            if (mode == 1) begin req1_a = $urandom; req1_b = mutate(req1_a); end
            else req1_valid = 1'b0;
        end
        if (mode == 2) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_a = $urandom; req0_b = mutate(req0_a);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_a = $urandom; req1_b = mutate(req1_a);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while ((req0_valid || req1_valid || q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", n < 200, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fields", {rsp_id, rsp_equal, rsp_index}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        req0_valid = 1'b1; req0_a = 16'hA5A5; req0_b = 16'hA5A5; rsp_ready = 1'b1;
        run_until_idle();
        check("t1_lat", last_lat, 5);
        check("t1_fields", {last_id, last_eq, last_idx}, {32'd0, 32'd1, 32'd0});

        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h1294;
        run_until_idle();
        check("t2_lat", last_lat, 3);
        check("t2_fields", {last_id, last_eq, last_idx}, {32'd1, 32'd0, 32'd1});

        req0_valid = 1'b1; req0_a = 16'h000F; req0_b = 16'h0000;
        run_until_idle();
        check("t3_lat", last_lat, 2);
        check("t3_fields", {last_id, last_eq, last_idx}, {32'd0, 32'd0, 32'd0});

        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h5A5A; req1_b = 16'h5A5A;
        for (int n = 0; n < 20 && !rsp_valid; n++) step();
        check("hold_reached_resp", rsp_valid, 1);
        req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0102;
        for (int n = 0; n < 3; n++) step();
        rsp_ready = 1'b1;
        run_until_idle();
        check("hold_last_id", last_id, 0);

        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        step();
        step();
        check("midrst_in_cmp", busy, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {rsp_valid, busy, rsp_id, rsp_equal, rsp_index, req0_ready, req1_ready}, 0);
        q.delete(); seen = 0; lg = 1; grants.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mode = 1;
        for (int n = 0; n < 100 && grants.size() < 4; n++) step();
        mode = 0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_until_idle();
        check("rr_count", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            check("rr_order0", grants[0], 0);
            check("rr_order1", grants[1], 1);
            check("rr_order2", grants[2], 0);
            check("rr_order3", grants[3], 1);
        end

        mode = 2;
        for (int n = 0; n < 3000; n++) step();
        mode = 0;
        rsp_ready = 1'b1;
        run_until_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
